// File: rtl/stepper_axis.sv
// stepper_axis: single-axis step/dir pulse generator with homing, abort and driver-fault handling.
// Define STEPPER_RAMP_EN to build the trapezoidal acceleration/deceleration ramp.
module stepper_axis #(
    parameter int CNT_W     = 24,
    parameter int DIV_W     = 20,
    parameter int MSTEP     = 7,
    parameter int PER_START = 20000,
    parameter int RAMP_DEC  = 16
) (
    input  logic                    clk_100M,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic                    cmd_home,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [DIV_W-1:0]        cmd_period,
    input  logic                    abort,
    input  logic                    fault_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic                    home_err,
    output logic signed [CNT_W-1:0] pos,
    output logic                    mtr_step,
    output logic                    mtr_dir,
    output logic                    mtr_nen,
    output logic                    mtr_slp,
    output logic                    mtr_nrst,
    output logic                    mtr_decay,
    output logic [2:0]              mtr_m,
    input  logic                    mtr_nhome,
    input  logic                    mtr_nflt
);
    typedef enum logic [2:0] {IDLE, RUN, HOME, DONE, FAULT} state_t;

    state_t           state, state_next;
    logic [1:0]       nhome_sync, nflt_sync;
    logic             nhome_s, nflt_s;
    logic             step_q, in_step;
    logic [CNT_W-1:0] remain;
    logic [DIV_W-1:0] period_q, cnt, per_use, half;
    logic             active, accept, phase_end, rise, fall, finish, home_hit, stop;

    if (PER_START < 2 || PER_START >= 2**DIV_W || RAMP_DEC < 0 || MSTEP < 0 || MSTEP > 7)
        begin : g_bad_params
            $error("stepper_axis: PER_START, RAMP_DEC or MSTEP out of range");
        end

    assign mtr_m     = 3'(MSTEP);
    assign mtr_decay = 1'b1;
    assign mtr_slp   = 1'b1;
    assign mtr_nrst  = ~rst;
    assign nhome_s   = nhome_sync[1];
    assign nflt_s    = nflt_sync[1];

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            nhome_sync <= 2'b11;
            nflt_sync  <= 2'b11;
        end else begin
            nhome_sync <= {nhome_sync[0], mtr_nhome};
            nflt_sync  <= {nflt_sync[0], mtr_nflt};
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        active     = (state == RUN) || (state == HOME);
        cmd_ready  = (state == IDLE) && !rst && nflt_s;
        accept     = cmd_valid && cmd_ready;
        phase_end  = (cnt == '0);
        rise       = active && !step_q && phase_end && (remain != '0);
        fall       = active && step_q && phase_end;
        finish     = active && !step_q && phase_end && (remain == '0);
        home_hit   = (state == HOME) && !nhome_s;
        stop       = active && (abort || !nflt_s);
        busy       = active && !rst;
        mtr_nen    = !active || rst;
        done       = (state == DONE) && !rst;
        fault      = (state == FAULT) && !rst;
        mtr_step   = step_q && !rst;
        unique case (state)
            IDLE:      if (accept) state_next = (cmd_steps == '0) ? DONE : (cmd_home ? HOME : RUN);
            RUN, HOME: if (abort || home_hit || finish) state_next = DONE;
            DONE:      state_next = IDLE;
            FAULT:     if (fault_clr && nflt_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (!nflt_s) state_next = FAULT;
    end

    // cnt counts down the current phase; a step that is cut short is taken back off pos.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            mtr_dir  <= 1'b0;
            remain   <= '0;
            period_q <= DIV_W'(2);
            cnt      <= '0;
            step_q   <= 1'b0;
            in_step  <= 1'b0;
            pos      <= '0;
            home_err <= 1'b0;
        end else if (accept) begin
            mtr_dir  <= cmd_dir;
            remain   <= cmd_steps;
            period_q <= (cmd_period < DIV_W'(2)) ? DIV_W'(2) : cmd_period;
            cnt      <= DIV_W'(1);
            step_q   <= 1'b0;
            in_step  <= 1'b0;
            home_err <= 1'b0;
        end else if (stop) begin
            step_q  <= 1'b0;
            in_step <= 1'b0;
            if (in_step) pos <= mtr_dir ? pos - CNT_W'(1) : pos + CNT_W'(1);
        end else if (home_hit) begin
            step_q  <= 1'b0;
            in_step <= 1'b0;
            pos     <= '0;
        end else if (rise) begin
            step_q  <= 1'b1;
            in_step <= 1'b1;
            remain  <= remain - CNT_W'(1);
            cnt     <= per_use - DIV_W'(1);
            pos     <= mtr_dir ? pos + CNT_W'(1) : pos - CNT_W'(1);
        end else if (fall) begin
            step_q <= 1'b0;
            cnt    <= half - DIV_W'(1);
        end else if (finish) begin
            in_step <= 1'b0;
            if (state == HOME) home_err <= 1'b1;
        end else if (active) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

`ifdef STEPPER_RAMP_EN
    localparam logic [DIV_W-1:0] START = DIV_W'(PER_START);
    localparam logic [DIV_W-1:0] DEC   = DIV_W'(RAMP_DEC);

    logic [DIV_W-1:0] cur_per, ramp_top;
    logic [CNT_W-1:0] acc_steps;
    logic             first, acc_inc;

    // Deceleration mirrors the acceleration steps taken; homing only ever accelerates.
    always_comb begin
        ramp_top = (START > period_q) ? START : period_q;
        acc_inc  = 1'b0;
        if (first) begin
            per_use = ramp_top;
        end else if (state == RUN && remain <= acc_steps) begin
            per_use = (ramp_top - cur_per > DEC) ? cur_per + DEC : ramp_top;
        end else if (cur_per > period_q) begin
            acc_inc = 1'b1;
            per_use = (cur_per - period_q > DEC) ? cur_per - DEC : period_q;
        end else begin
            per_use = cur_per;
        end
    end

    assign half = cur_per;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            cur_per   <= DIV_W'(2);
            acc_steps <= '0;
            first     <= 1'b1;
        end else if (accept) begin
            acc_steps <= '0;
            first     <= 1'b1;
        end else if (rise) begin
            cur_per <= per_use;
            first   <= 1'b0;
            if (acc_inc) acc_steps <= acc_steps + CNT_W'(1);
        end
    end
`else
    assign per_use = period_q;
    assign half    = period_q;
`endif

endmodule
